// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: bundle of the requester handshake and the
// I2C_Controller GO/END/ACK handshake seen by i2c_cmd_arbiter.
// master = arbiter side, slave = requesters plus controller side.
interface i2c_cmd_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    REQ;
  logic [24*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]    GNT;
  logic [N_REQ-1:0]    DONE;
  logic [N_REQ-1:0]    ERR;
  logic                BUSY;
  logic [23:0]         I2C_DATA;
  logic                GO;
  logic                END;
  logic                ACK;

  modport master (
    input  REQ, REQ_DATA, END, ACK,
    output GNT, DONE, ERR, BUSY, I2C_DATA, GO
  );

  modport slave (
    output REQ, REQ_DATA, END, ACK,
    input  GNT, DONE, ERR, BUSY, I2C_DATA, GO
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C_Controller between N_REQ command sources.
// Grants one requester at a time, latches its 24-bit word, drives the
// GO/END/ACK handshake, relaunches NACKed transfers and pulses DONE/ERR.
// Optional macro I2C_ARB_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; the round-robin pointer is then held at 0.
module i2c_cmd_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023,
  parameter int GAP_CYC   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  i2c_cmd_arbiter_if.master bus
);

  localparam int              IDXW      = $clog2(N_REQ);
  localparam int              SUMW      = IDXW + 1;
  localparam logic [SUMW-1:0] N_SUM     = SUMW'(N_REQ);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N_REQ - 1);
  localparam logic [3:0]      RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [9:0]      TO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_END,
    OK,
    FAIL,
    GAP
  } stateT;

  stateT            state, stateNext;
  logic [N_REQ-1:0] gnt, gntNext;
  logic [N_REQ-1:0] done, doneNext;
  logic [N_REQ-1:0] err, errNext;
  logic             go, goNext;
  logic [23:0]      i2cData, i2cDataNext;
  logic [3:0]       retry, retryNext;
  logic             retryPend, retryPendNext;
  logic [9:0]       toCnt, toCntNext;
  logic [3:0]       gapCnt, gapCntNext;
  logic [IDXW-1:0]  ptr, ptrNext;

  logic [IDXW-1:0]  winIdx;
  logic             anyReq;
  logic [SUMW-1:0]  candSum;

  // Pick the winning requester: scan from the pointer (or from 0 in priority mode).
  always_comb begin
    winIdx  = '0;
    anyReq  = 1'b0;
    candSum = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef I2C_ARB_PRIO_EN
      candSum = SUMW'(k);
`else
      candSum = {1'b0, ptr} + SUMW'(k);
      if (candSum >= N_SUM) begin
        candSum = candSum - N_SUM;
      end
`endif
      if (!anyReq && bus.REQ[candSum[IDXW-1:0]]) begin
        anyReq = 1'b1;
        winIdx = candSum[IDXW-1:0];
      end
    end
  end

  // Transaction sequencing: next state and next value of every registered output.
  always_comb begin
    stateNext     = state;
    gntNext       = gnt;
    doneNext      = '0;
    errNext       = '0;
    goNext        = go;
    i2cDataNext   = i2cData;
    retryNext     = retry;
    retryPendNext = retryPend;
    toCntNext     = '0;
    gapCntNext    = '0;
    ptrNext       = ptr;
    unique case (state)
      IDLE: begin
        if (anyReq) begin
          gntNext         = '0;
          gntNext[winIdx] = 1'b1;
          i2cDataNext     = bus.REQ_DATA[24*winIdx +: 24];
          retryNext       = '0;
          retryPendNext   = 1'b0;
`ifdef I2C_ARB_PRIO_EN
          ptrNext         = '0;
`else
          ptrNext         = (winIdx == LAST_IDX) ? '0 : winIdx + 1'b1;
`endif
          stateNext       = LAUNCH;
        end
      end
      LAUNCH: begin
        goNext        = 1'b1;
        retryPendNext = 1'b0;
        stateNext     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.END) begin
          stateNext = WAIT_END;
        end else if (toCnt == TO_LAST) begin
          stateNext = FAIL;
        end else begin
          toCntNext = toCnt + 1'b1;
        end
      end
      WAIT_END: begin
        if (bus.END) begin
          goNext = 1'b0;
          if (!bus.ACK) begin
            stateNext = OK;
          end else if (retry < RETRY_LIM) begin
            retryNext     = retry + 1'b1;
            retryPendNext = 1'b1;
            stateNext     = GAP;
          end else begin
            stateNext = FAIL;
          end
        end else if (toCnt == TO_LAST) begin
          stateNext = FAIL;
        end else begin
          toCntNext = toCnt + 1'b1;
        end
      end
      OK: begin
        doneNext  = gnt;
        gntNext   = '0;
        stateNext = GAP;
      end
      FAIL: begin
        goNext    = 1'b0;
        errNext   = gnt;
        gntNext   = '0;
        stateNext = GAP;
      end
      GAP: begin
        goNext = 1'b0;
        if (gapCnt == GAP_LAST) begin
          stateNext = retryPend ? LAUNCH : IDLE;
        end else begin
          gapCntNext = gapCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by the active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      go        <= 1'b0;
      i2cData   <= '0;
      retry     <= '0;
      retryPend <= 1'b0;
      toCnt     <= '0;
      gapCnt    <= '0;
      ptr       <= '0;
    end else begin
      state     <= stateNext;
      gnt       <= gntNext;
      done      <= doneNext;
      err       <= errNext;
      go        <= goNext;
      i2cData   <= i2cDataNext;
      retry     <= retryNext;
      retryPend <= retryPendNext;
      toCnt     <= toCntNext;
      gapCnt    <= gapCntNext;
      ptr       <= ptrNext;
    end
  end

  assign bus.GNT      = gnt;
  assign bus.DONE     = done;
  assign bus.ERR      = err;
  assign bus.GO       = go;
  assign bus.I2C_DATA = i2cData;
  assign bus.BUSY     = (state != IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed and randomized checks of i2c_cmd_arbiter
// against a transaction-level model, with a behavioural I2C_Controller.
module tb_i2c_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int MAXR = 3;
  localparam int TOUT = 1023;
  localparam int GAPC = 4;

  logic CLK;
  logic RST;

  i2c_cmd_arbiter_if #(.N_REQ(NREQ)) bus ();

  i2c_cmd_arbiter #(
    .N_REQ(NREQ), .MAX_RETRY(MAXR), .TIMEOUT(TOUT), .GAP_CYC(GAPC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int          checks;
  int          errors;
  logic [23:0] reqData [NREQ];
  int          modelPtr;
  bit          stuckEnd;
  bit          longBusy;
  int          nackTarget;
  int          xferBase;
  int          ctlLaunches;
  int          ctlPhase;
  int          ctlCnt;
  int          goRises;
  int          lowRun;
  logic        prevGo;
  int          gapLen [0:255];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural I2C_Controller: starts a few cycles after GO, answers from nackTarget.
  initial begin
    bus.END     = 1'b1;
    bus.ACK     = 1'b0;
    ctlPhase    = 0;
    ctlCnt      = 0;
    ctlLaunches = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        bus.END  = 1'b1;
        ctlPhase = 0;
      end else begin
        case (ctlPhase)
          0: if (bus.GO && !stuckEnd) begin
               ctlLaunches++;
               ctlCnt   = $urandom_range(0, 3);
               ctlPhase = 1;
             end
          1: if (ctlCnt == 0) begin
               bus.END  = 1'b0;
               ctlCnt   = longBusy ? 40 : $urandom_range(2, 8);
               ctlPhase = 2;
             end else ctlCnt--;
          2: if (ctlCnt == 0) begin
               bus.ACK  = ((ctlLaunches - xferBase) <= nackTarget);
               bus.END  = 1'b1;
               ctlPhase = 3;
             end else ctlCnt--;
          3: if (!bus.GO) ctlPhase = 0;
          default: ctlPhase = 0;
        endcase
      end
    end
  end

  // GO monitor: counts launches and the GO-low run preceding each one.
  initial begin
    goRises = 0;
    lowRun  = 0;
    prevGo  = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.GO && !prevGo) begin
        goRises++;
        if (goRises < 256) gapLen[goRises] = lowRun;
      end
      if (!bus.GO) lowRun++;
      else lowRun = 0;
      prevGo = bus.GO;
    end
  end

  function automatic int pickWinner(input int ptr, input logic [NREQ-1:0] mask);
    int start;
`ifdef I2C_ARB_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    bus.REQ = mask;
    for (int j = 0; j < NREQ; j++) bus.REQ_DATA[24*j +: 24] = reqData[j];
  endtask

  task automatic waitIdle(input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge CLK);
      found = !bus.BUSY;
    end
    checkOutput({tag, ".idle"}, 32'(found), 32'd1);
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    modelPtr = 0;
  endtask

  // One transaction: fresh = start from IDLE and drop REQ right after the grant.
  task automatic runXfer(input logic [NREQ-1:0] mask, input int nack, input bit fresh,
                         input bit toCase, input string tag);
    int              pick, expLaunch, launchBase, polls, goHigh, nL;
    bit              found, gapsOk, expOk;
    logic [NREQ-1:0] expOne, evDone, evErr;
    pick      = pickWinner(modelPtr, mask);
    expOne    = '0;
    expOne[pick] = 1'b1;
    expOk     = !toCase && (nack <= MAXR);
    expLaunch = toCase ? 1 : ((nack > MAXR) ? MAXR + 1 : nack + 1);
    nackTarget = nack;
    xferBase   = ctlLaunches;
    launchBase = goRises;
    goHigh     = 0;
    if (fresh) applyStimulus(mask);
    found = 1'b0;
    polls = 0;
    while (!found && polls < 40) begin
      @(negedge CLK);
      polls++;
      found = (bus.GNT != '0);
    end
    checkOutput({tag, ".granted"}, 32'(found), 32'd1);
    checkOutput({tag, ".gnt"}, 32'(bus.GNT), 32'(expOne));
    checkOutput({tag, ".data"}, 32'(bus.I2C_DATA), 32'(reqData[pick]));
`ifdef I2C_ARB_PRIO_EN
    modelPtr = 0;
`else
    modelPtr = (pick + 1) % NREQ;
`endif
    if (fresh) begin
      checkOutput({tag, ".grantLatency"}, 32'(polls), 32'd1);
      applyStimulus('0);
      @(negedge CLK);
      checkOutput({tag, ".goLatency"}, 32'(bus.GO), 32'd1);
      if (bus.GO) goHigh++;
    end
    found  = 1'b0;
    polls  = 0;
    evDone = '0;
    evErr  = '0;
    while (!found && polls < 1500) begin
      @(negedge CLK);
      polls++;
      if ((bus.DONE | bus.ERR) != '0) begin
        found  = 1'b1;
        evDone = bus.DONE;
        evErr  = bus.ERR;
      end else if (bus.GO) begin
        goHigh++;
      end
    end
    checkOutput({tag, ".event"}, 32'(found), 32'd1);
    checkOutput({tag, ".done"}, 32'(evDone), expOk ? 32'(expOne) : 32'd0);
    checkOutput({tag, ".err"}, 32'(evErr), expOk ? 32'd0 : 32'(expOne));
    checkOutput({tag, ".gntAtEvent"}, 32'(bus.GNT), 32'd0);
    nL = goRises - launchBase;
    checkOutput({tag, ".launches"}, 32'(nL), 32'(expLaunch));
    if (nL > 1) begin
      gapsOk = 1'b1;
      for (int k = launchBase + 2; k <= launchBase + nL && k < 256; k++) begin
        if (gapLen[k] < GAPC) gapsOk = 1'b0;
      end
      checkOutput({tag, ".gapLen"}, 32'(gapsOk), 32'd1);
    end
    if (toCase) begin
      checkOutput({tag, ".goAtErr"}, 32'(bus.GO), 32'd0);
      checkOutput({tag, ".timeoutLen"}, 32'(goHigh >= TOUT && goHigh <= TOUT + 3), 32'd1);
    end
    @(negedge CLK);
    checkOutput({tag, ".pulseWidth"}, 32'(bus.DONE | bus.ERR), 32'd0);
    if (fresh) waitIdle(tag);
  endtask

  // Directed scenarios followed by randomized transactions.
  initial begin
    bit              found;
    logic [NREQ-1:0] rMask;
    int              rNack;
    checks     = 0;
    errors     = 0;
    modelPtr   = 0;
    stuckEnd   = 1'b0;
    longBusy   = 1'b0;
    nackTarget = 0;
    xferBase   = 0;
    for (int j = 0; j < NREQ; j++) reqData[j] = '0;
    bus.REQ      = '0;
    bus.REQ_DATA = '0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    checkOutput("reset.gnt", 32'(bus.GNT), 32'd0);
    checkOutput("reset.done", 32'(bus.DONE), 32'd0);
    checkOutput("reset.err", 32'(bus.ERR), 32'd0);
    checkOutput("reset.busy", 32'(bus.BUSY), 32'd0);
    checkOutput("reset.go", 32'(bus.GO), 32'd0);
    checkOutput("reset.data", 32'(bus.I2C_DATA), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    $display("[TB] single request");
    reqData[0] = 24'h341201;
    runXfer(2'b01, 0, 1'b1, 1'b0, "single");

    $display("[TB] contention");
    doReset();
    reqData[0] = 24'h34047B;
    reqData[1] = 24'h34067B;
    applyStimulus(2'b11);
    for (int i = 0; i < 4; i++) runXfer(2'b11, 0, 1'b0, 1'b0, $sformatf("contend%0d", i));
    applyStimulus('0);
    waitIdle("contend");

    $display("[TB] NACK retry and exhaustion");
    reqData[1] = 24'h340A55;
    runXfer(2'b10, 2, 1'b1, 1'b0, "nackRetry");
    reqData[0] = 24'h3410C3;
    runXfer(2'b01, 99, 1'b1, 1'b0, "exhaust");

    $display("[TB] timeout");
    stuckEnd = 1'b1;
    runXfer(2'b01, 0, 1'b1, 1'b1, "timeout");
    stuckEnd = 1'b0;

    $display("[TB] reset mid-transfer");
    longBusy = 1'b1;
    applyStimulus(2'b01);
    @(negedge CLK);
    applyStimulus('0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge CLK);
      found = !bus.END;
    end
    checkOutput("midReset.started", 32'(found), 32'd1);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midReset.go", 32'(bus.GO), 32'd0);
    checkOutput("midReset.gnt", 32'(bus.GNT), 32'd0);
    checkOutput("midReset.busy", 32'(bus.BUSY), 32'd0);
    repeat (2) @(negedge CLK);
    RST      = 1'b1;
    longBusy = 1'b0;
    modelPtr = 0;
    reqData[1] = 24'h3408AA;
    runXfer(2'b10, 0, 1'b1, 1'b0, "postReset");

    $display("[TB] randomized transactions");
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < NREQ; j++) reqData[j] = 24'($urandom);
      rMask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rNack = $urandom_range(0, MAXR + 1);
      runXfer(rMask, rNack, 1'b1, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
